dac_spi_receiver: RTL and testbench
===================================

# dac_spi_receiver

Receive-side model of the laser projector's X/Y galvo DAC serial link. It deserializes the 16-bit words sent on `dac_csn`/`dac_sclk`/`dac_mosi` and double-buffers them per channel. On a `dac_latchn` falling edge it transfers both buffered codes to parallel outputs. It sits on the FPGA as a loopback checker on the HDR1 DAC pins and in benches as the DAC stand-in, all logic in the system `clk` domain.

## Interface
- `WORD_BITS`, 16: bits per frame, MSB first.
- `DATA_BITS`, 12: code width, taken from word bits [11:0].
- `SYNC_STAGES`, 2: synchronizer depth on each serial input, at least 2.
- `clk` in 1: system clock, 50 MHz. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `dac_csn` in 1: frame select, active low, asynchronous to `clk`.
- `dac_sclk` in 1: serial clock; data sampled on its rising edge.
- `dac_mosi` in 1: serial data.
- `dac_latchn` in 1: load DAC; falling edge transfers the input registers to the outputs.
- `out_a` out DATA_BITS: channel A (X) code.
- `out_b` out DATA_BITS: channel B (Y) code.
- `shdn_a`, `shdn_b` out 1: channel shut down.
- `word_strobe` out 1: one-cycle pulse when a word is accepted.
- `latch_strobe` out 1: one-cycle pulse when the outputs update.
- `frame_error` out 1: one-cycle pulse when a frame is discarded.
- `busy` out 1: high while a frame is open.

## Operation
- All four serial inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronized copies only.
- FSM states:
  - IDLE: on `csn` falling, clear the shift register and bit count, then go to SHIFT.
  - SHIFT: each `sclk` rising edge shifts `mosi` into the LSB and increments the count, which saturates at WORD_BITS+1.
  - On `csn` rising in SHIFT:
    - count == WORD_BITS: commit the word and pulse `word_strobe`.
    - any other count: pulse `frame_error` and leave the input registers unchanged.
    - Either way, return to IDLE.
- Word fields: bit 15 selects the channel (0 = A, 1 = B). Bit 12 is SHDN, active low. Bits 14:13 are ignored. Commit writes bits [11:0] and the SHDN bit into the selected channel's input register.
- `sclk` edges seen in IDLE are ignored.
- On `latchn` falling, both input registers are copied to `out_a/out_b/shdn_a/shdn_b` and `latch_strobe` pulses. This happens in any FSM state; an open frame continues unaffected.
- If a `csn` rising and a `latchn` falling are detected in the same cycle, the commit takes effect first, so the latched values include the new word.
- `busy` = (state == SHIFT).

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - Input registers hold code 0 with SHDN = 1 (not shut down).
  - Synchronizer flops are 0.
- Latency: a pin edge sampled at `clk` edge k produces its strobe or output update registered at edge k+SYNC_STAGES+1.
- `dac_sclk` high and low times are each at least 2 `clk` periods. At 50 MHz, sclk is at most 12.5 MHz.
- `csn` setup and hold to `sclk` is at least 2 `clk` periods.
- A reset asserted mid-frame aborts the frame with no `frame_error`. The next complete frame after release is accepted normally.

## Configuration
- `DAC_RX_SHDN_EN` defined:
  - A latched SHDN bit of 0 forces that channel's output code to 0 and drives its `shdn_x` high.
  - The input register keeps the received code, and the next latch with SHDN = 1 restores it.
- `DAC_RX_SHDN_EN` undefined:
  - The SHDN bit is ignored and codes always pass through.
  - `shdn_a` and `shdn_b` are tied to 0.

## Structure
- Package `dac_spi_pkg` holds:
  - constants `CH_SEL_BIT = 15` and `SHDN_BIT = 12`;
  - `DEF_WORD_BITS` and `DEF_DATA_BITS`;
  - the FSM state typedef (IDLE, SHIFT).
- Sub-module `sync_edge` (parameter `SYNC_STAGES`): a synchronizer chain plus registered rise and fall pulses. It is instantiated four times, once per serial input.

## Test plan
- Send 16'h3ABC, then pulse `latchn` low → `word_strobe` once, `out_a` = 12'hABC, `out_b` = 0, `latch_strobe` once.
- Send 16'hB123 with no latch → `out_b` stays 0. Then pulse `latchn` → `out_b` = 12'h123 and `out_a` unchanged.
- Send 15-bit and 17-bit frames → `frame_error` pulses for each, no `word_strobe`, and the outputs after a following latch are unchanged.
- Assert `reset` after 8 bits of 16'h3FFF → all outputs 0, no error pulse. Then send 16'h3010 and latch → `out_a` = 12'h010.
- Make `csn` rising (word 16'hB7FF) and `latchn` falling land in the same `clk` cycle → `out_b` = 12'h7FF at that latch.
- With the macro defined, send 16'h2555 and latch → `out_a` = 0, `shdn_a` = 1. Then send 16'h3555 and latch → `out_a` = 12'h555, `shdn_a` = 0. Without the macro, the first latch gives `out_a` = 12'h555 and `shdn_a` = 0.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg
// Shared constants and types for the galvo DAC serial receiver.
//   CH_SEL_BIT     - word bit selecting channel (0 = A/X, 1 = B/Y)
//   SHDN_BIT       - word bit carrying the active-low shutdown flag
//   DEF_WORD_BITS  - default frame length in bits
//   DEF_DATA_BITS  - default DAC code width
//   rx_state_t     - receiver FSM states
package dac_spi_pkg;

   localparam int CH_SEL_BIT    = 15;
   localparam int SHDN_BIT      = 12;
   localparam int DEF_WORD_BITS = 16;
   localparam int DEF_DATA_BITS = 12;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/dac_spi_receiver_sync_edge.sv
// sync_edge
// Synchronizer chain for one asynchronous pin plus registered edge pulses.
// Ports:
//   clk    in  - system clock
//   reset  in  - asynchronous active-high reset (all flops to 0)
//   din    in  - asynchronous pin
//   level  out - synchronized level, time-aligned with rise/fall pulses
//   rise   out - one-cycle pulse on a synchronized 0->1 transition
//   fall   out - one-cycle pulse on a synchronized 1->0 transition
// Parameter SYNC_STAGES: synchronizer depth (>= 2).
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_reg;
   logic                   last_reg;
   logic                   rise_reg;
   logic                   fall_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) chain_reg[gi] <= 1'b0;
               else       chain_reg[gi] <= din;
            end
         end else begin : g_rest
            always_ff @(posedge clk or posedge reset) begin
               if (reset) chain_reg[gi] <= 1'b0;
               else       chain_reg[gi] <= chain_reg[gi-1];
            end
         end
      end
   endgenerate

   // last_reg is the delayed synchronized copy; exporting it as the level
   // keeps the data pin aligned with the clock pin's registered edge pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_reg <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         last_reg <= chain_reg[SYNC_STAGES-1];
         rise_reg <= chain_reg[SYNC_STAGES-1] & ~last_reg;
         fall_reg <= ~chain_reg[SYNC_STAGES-1] & last_reg;
      end
   end

   assign level = last_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver
// Receive-side model of the X/Y galvo DAC serial link. Deserializes 16-bit
// MSB-first words framed by dac_csn, double-buffers them per channel and
// transfers both channels to the outputs on a dac_latchn falling edge.
// Ports:
//   clk, reset              - system clock, asynchronous active-high reset
//   dac_csn/sclk/mosi       - serial frame select, clock, data (async pins)
//   dac_latchn              - load strobe, falling edge updates outputs
//   out_a, out_b            - channel A (X) / B (Y) output codes
//   shdn_a, shdn_b          - channel shutdown indications
//   word_strobe             - pulse: word committed to an input register
//   latch_strobe            - pulse: outputs updated
//   frame_error             - pulse: frame discarded (wrong bit count)
//   busy                    - frame open
// Configuration macro DAC_RX_SHDN_EN: when defined, a latched SHDN=0 forces
// the channel code to 0 and raises shdn_x; when undefined SHDN is ignored.
module dac_spi_receiver
   import dac_spi_pkg::*;
#(
   parameter int WORD_BITS   = DEF_WORD_BITS,
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dac_csn,
   input  logic                 dac_sclk,
   input  logic                 dac_mosi,
   input  logic                 dac_latchn,
   output logic [DATA_BITS-1:0] out_a,
   output logic [DATA_BITS-1:0] out_b,
   output logic                 shdn_a,
   output logic                 shdn_b,
   output logic                 word_strobe,
   output logic                 latch_strobe,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WORD_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);

   // ---------------- pin synchronizers ----------------
   logic [3:0] pin_in;
   logic [3:0] pin_level;
   logic [3:0] pin_rise;
   logic [3:0] pin_fall;

   assign pin_in = {dac_latchn, dac_mosi, dac_sclk, dac_csn};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pin
         sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (pin_in[gi]),
            .level (pin_level[gi]),
            .rise  (pin_rise[gi]),
            .fall  (pin_fall[gi])
         );
      end
   endgenerate

   logic csn_fall, csn_rise, sclk_rise, mosi_level, latch_fall;
   assign csn_fall   = pin_fall[0];
   assign csn_rise   = pin_rise[0];
   assign sclk_rise  = pin_rise[1];
   assign mosi_level = pin_level[2];
   assign latch_fall = pin_fall[3];

   // ---------------- state ----------------
   rx_state_t             state_reg, state_next;
   logic [WORD_BITS-1:0]  shift_reg, shift_next;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic [DATA_BITS-1:0]  code_a_reg, code_a_next;
   logic [DATA_BITS-1:0]  code_b_reg, code_b_next;
   logic                  shdn_in_a_reg, shdn_in_a_next;
   logic                  shdn_in_b_reg, shdn_in_b_next;
   logic [DATA_BITS-1:0]  out_a_reg, out_a_next;
   logic [DATA_BITS-1:0]  out_b_reg, out_b_next;
   logic                  shdn_a_reg, shdn_a_next;
   logic                  shdn_b_reg, shdn_b_next;
   logic                  word_strobe_reg, word_strobe_next;
   logic                  latch_strobe_reg, latch_strobe_next;
   logic                  frame_error_reg, frame_error_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         shift_reg        <= '0;
         count_reg        <= '0;
         code_a_reg       <= '0;
         code_b_reg       <= '0;
         shdn_in_a_reg    <= 1'b1;
         shdn_in_b_reg    <= 1'b1;
         out_a_reg        <= '0;
         out_b_reg        <= '0;
         shdn_a_reg       <= 1'b0;
         shdn_b_reg       <= 1'b0;
         word_strobe_reg  <= 1'b0;
         latch_strobe_reg <= 1'b0;
         frame_error_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         shift_reg        <= shift_next;
         count_reg        <= count_next;
         code_a_reg       <= code_a_next;
         code_b_reg       <= code_b_next;
         shdn_in_a_reg    <= shdn_in_a_next;
         shdn_in_b_reg    <= shdn_in_b_next;
         out_a_reg        <= out_a_next;
         out_b_reg        <= out_b_next;
         shdn_a_reg       <= shdn_a_next;
         shdn_b_reg       <= shdn_b_next;
         word_strobe_reg  <= word_strobe_next;
         latch_strobe_reg <= latch_strobe_next;
         frame_error_reg  <= frame_error_next;
      end
   end

   // Frame FSM and input-register commit.
   always_comb begin
      state_next       = state_reg;
      shift_next       = shift_reg;
      count_next       = count_reg;
      code_a_next      = code_a_reg;
      code_b_next      = code_b_reg;
      shdn_in_a_next   = shdn_in_a_reg;
      shdn_in_b_next   = shdn_in_b_reg;
      word_strobe_next = 1'b0;
      frame_error_next = 1'b0;

      case (state_reg)
         IDLE: begin
            // sclk edges here are ignored by construction
            if (csn_fall) begin
               shift_next = '0;
               count_next = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               state_next = IDLE;
               if (count_reg == CNT_FULL) begin
                  word_strobe_next = 1'b1;
                  if (shift_reg[CH_SEL_BIT]) begin
                     code_b_next    = shift_reg[DATA_BITS-1:0];
                     shdn_in_b_next = shift_reg[SHDN_BIT];
                  end else begin
                     code_a_next    = shift_reg[DATA_BITS-1:0];
                     shdn_in_a_next = shift_reg[SHDN_BIT];
                  end
               end else begin
                  frame_error_next = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_next = {shift_reg[WORD_BITS-2:0], mosi_level};
               // saturating count still distinguishes "too long" from "exact"
               if (count_reg != CNT_MAX) count_next = count_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output latch. Uses the *_next input-register values so a commit in the
   // same cycle as the latch edge is included in the transferred codes.
   always_comb begin
      out_a_next        = out_a_reg;
      out_b_next        = out_b_reg;
      shdn_a_next       = shdn_a_reg;
      shdn_b_next       = shdn_b_reg;
      latch_strobe_next = 1'b0;
      if (latch_fall) begin
         latch_strobe_next = 1'b1;
`ifdef DAC_RX_SHDN_EN
         out_a_next  = shdn_in_a_next ? code_a_next : '0;
         out_b_next  = shdn_in_b_next ? code_b_next : '0;
         shdn_a_next = ~shdn_in_a_next;
         shdn_b_next = ~shdn_in_b_next;
`else
         out_a_next  = code_a_next;
         out_b_next  = code_b_next;
         shdn_a_next = 1'b0;
         shdn_b_next = 1'b0;
`endif
      end
   end

   // Sink for synchronizer outputs this block does not need.
   logic unused_pins;
   assign unused_pins = &{1'b0, pin_level[1:0], pin_level[3], pin_rise[3:2],
                          pin_fall[2:1], shift_reg[WORD_BITS-1:DATA_BITS]};

   assign out_a        = out_a_reg;
   assign out_b        = out_b_reg;
`ifdef DAC_RX_SHDN_EN
   assign shdn_a       = shdn_a_reg;
   assign shdn_b       = shdn_b_reg;
`else
   assign shdn_a       = 1'b0;
   assign shdn_b       = 1'b0;
   logic unused_shdn;
   assign unused_shdn  = &{1'b0, shdn_a_reg, shdn_b_reg};
`endif
   assign word_strobe  = word_strobe_reg;
   assign latch_strobe = latch_strobe_reg;
   assign frame_error  = frame_error_reg;
   assign busy         = (state_reg == SHIFT);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb_dac_spi_receiver
// Self-checking bench for dac_spi_receiver: directed cases followed by
// randomized frames/latches compared against a word-level reference model.
// Honours DAC_RX_SHDN_EN the same way as the design.
module tb_dac_spi_receiver;

   localparam int SYNC = 2;
   localparam int DW   = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dac_csn = 1'b1;
   logic          dac_sclk = 1'b0;
   logic          dac_mosi = 1'b0;
   logic          dac_latchn = 1'b1;
   logic [DW-1:0] out_a, out_b;
   logic          shdn_a, shdn_b;
   logic          word_strobe, latch_strobe, frame_error, busy;

   dac_spi_receiver #(.WORD_BITS(16), .DATA_BITS(DW), .SYNC_STAGES(SYNC)) dut (
      .clk          (clk),
      .reset        (reset),
      .dac_csn      (dac_csn),
      .dac_sclk     (dac_sclk),
      .dac_mosi     (dac_mosi),
      .dac_latchn   (dac_latchn),
      .out_a        (out_a),
      .out_b        (out_b),
      .shdn_a       (shdn_a),
      .shdn_b       (shdn_b),
      .word_strobe  (word_strobe),
      .latch_strobe (latch_strobe),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   always #10 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int ws_cnt = 0, ls_cnt = 0, fe_cnt = 0;

   // Pulse counters sampled mid-cycle, away from both clock edges.
   always @(posedge clk) begin
      #5;
      if (!reset) begin
         if (word_strobe)  ws_cnt++;
         if (latch_strobe) ls_cnt++;
         if (frame_error)  fe_cnt++;
      end
   end

   // Reference model: per-channel input register (code, SHDN) and outputs.
   int m_code[2];
   int m_shdn[2];
   int m_out[2];
   int m_oshdn[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_code[c] = 0; m_shdn[c] = 1; m_out[c] = 0; m_oshdn[c] = 0;
      end
   endtask

   task automatic model_commit(input logic [15:0] w);
      int c;
      c = w[15] ? 1 : 0;
      m_code[c] = int'(w[11:0]);
      m_shdn[c] = w[12] ? 1 : 0;
   endtask

   task automatic model_latch();
      for (int c = 0; c < 2; c++) begin
`ifdef DAC_RX_SHDN_EN
         m_out[c]   = (m_shdn[c] != 0) ? m_code[c] : 0;
         m_oshdn[c] = (m_shdn[c] != 0) ? 0 : 1;
`else
         m_out[c]   = m_code[c];
         m_oshdn[c] = 0;
`endif
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".out_a"},  out_a,  m_out[0]);
      check_eq({tag, ".out_b"},  out_b,  m_out[1]);
      check_eq({tag, ".shdn_a"}, shdn_a, m_oshdn[0]);
      check_eq({tag, ".shdn_b"}, shdn_b, m_oshdn[1]);
   endtask

   // Sends n bits (LSBs of w, MSB first). with_latch drops latchn in the
   // same instant csn rises. Strobe latency is measured from that edge.
   task automatic send_frame(input logic [31:0] w, input int n, input bit with_latch);
      int ws0, fe0, ls0, lat;
      ws0 = ws_cnt; fe0 = fe_cnt; ls0 = ls_cnt;
      dac_csn = 1'b0;
      clks(3);
      for (int i = n - 1; i >= 0; i--) begin
         dac_mosi = w[i];
         clks(3);
         dac_sclk = 1'b1;
         clks(3);
         dac_sclk = 1'b0;
         if (i == n / 2) check_eq("busy_mid", busy, 1);
      end
      clks(3);
      dac_csn = 1'b1;
      if (with_latch) dac_latchn = 1'b0;
      lat = -1;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         @(posedge clk);
         #1;
         if (word_strobe || frame_error) lat = c;
      end
      clks(6);
      dac_latchn = 1'b1;
      clks(6);
      if (n == 16) model_commit(w[15:0]);
      if (with_latch) model_latch();
      check_eq("strobe_latency", lat, SYNC + 2);
      check_eq("word_strobe_cnt", ws_cnt - ws0, (n == 16) ? 1 : 0);
      check_eq("frame_error_cnt", fe_cnt - fe0, (n == 16) ? 0 : 1);
      check_eq("latch_cnt_frame", ls_cnt - ls0, with_latch ? 1 : 0);
      check_eq("busy_idle", busy, 0);
      check_outputs("frame");
      $display("[TB] frame n=%0d word=%h latch=%0d out_a=%h out_b=%h", n, w[15:0], with_latch, out_a, out_b);
   endtask

   task automatic do_latch();
      int ls0;
      ls0 = ls_cnt;
      dac_latchn = 1'b0;
      clks(6);
      dac_latchn = 1'b1;
      clks(6);
      model_latch();
      check_eq("latch_cnt", ls_cnt - ls0, 1);
      check_outputs("latch");
      $display("[TB] latch out_a=%h out_b=%h shdn_a=%0d shdn_b=%0d", out_a, out_b, shdn_a, shdn_b);
   endtask

   initial begin
      logic [31:0] w;
      int fe0, n, kind;
      model_reset();
      clks(4);
      check_eq("rst.out_a", out_a, 0);
      check_eq("rst.out_b", out_b, 0);
      check_eq("rst.busy", busy, 0);
      check_eq("rst.strobes", {word_strobe, latch_strobe, frame_error}, 0);
      reset = 1'b0;
      clks(8);
      check_eq("post_rst.cnt", ws_cnt + ls_cnt + fe_cnt, 0);

      // Basic word then latch.
      send_frame(32'h3ABC, 16, 1'b0);
      do_latch();
      check_eq("d1.out_a", out_a, 12'hABC);
      check_eq("d1.out_b", out_b, 12'h000);

      // Channel B buffered until latch.
      send_frame(32'hB123, 16, 1'b0);
      check_eq("d2.out_b_held", out_b, 12'h000);
      do_latch();
      check_eq("d2.out_b", out_b, 12'h123);
      check_eq("d2.out_a", out_a, 12'hABC);

      // Short and long frames are discarded.
      send_frame(32'h5FFF, 15, 1'b0);
      send_frame(32'h1BFFF, 17, 1'b0);
      do_latch();
      check_eq("d3.out_a", out_a, 12'hABC);
      check_eq("d3.out_b", out_b, 12'h123);

      // Reset mid-frame: no error, outputs cleared.
      fe0 = fe_cnt;
      w = 32'h3FFF;
      dac_csn = 1'b0;
      clks(3);
      for (int i = 15; i >= 8; i--) begin
         dac_mosi = w[i];
         clks(3);
         dac_sclk = 1'b1;
         clks(3);
         dac_sclk = 1'b0;
      end
      reset = 1'b1;
      model_reset();
      clks(2);
      check_eq("d4.busy", busy, 0);
      check_outputs("d4");
      dac_csn = 1'b1;
      clks(4);
      reset = 1'b0;
      clks(8);
      check_eq("d4.no_error", fe_cnt - fe0, 0);
      $display("[TB] reset mid-frame out_a=%h out_b=%h", out_a, out_b);
      send_frame(32'h3010, 16, 1'b0);
      do_latch();
      check_eq("d4.out_a", out_a, 12'h010);

      // Commit and latch detected in the same cycle.
      send_frame(32'hB7FF, 16, 1'b1);
      check_eq("d5.out_b", out_b, 12'h7FF);

      // SHDN handling.
      send_frame(32'h2555, 16, 1'b0);
      do_latch();
`ifdef DAC_RX_SHDN_EN
      check_eq("d6.out_a_shdn", out_a, 12'h000);
      check_eq("d6.shdn_a", shdn_a, 1);
      send_frame(32'h3555, 16, 1'b0);
      do_latch();
      check_eq("d6.out_a_restore", out_a, 12'h555);
      check_eq("d6.shdn_a_clear", shdn_a, 0);
`else
      check_eq("d6.out_a", out_a, 12'h555);
      check_eq("d6.shdn_a", shdn_a, 0);
`endif

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 9));
         w = $urandom;
         if (kind < 2) begin
            do_latch();
         end else begin
            n = (kind < 7) ? 16 : int'($urandom_range(14, 18));
            send_frame(w, n, kind == 6);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
